// File: rtl/matrix_print_streamer.sv
// rtl/matrix_print_streamer.sv - streams an m x n storage matrix as unsigned ASCII decimal text.
// One element per read: fetch, double-dabble to BCD, emit digits, then a space or CR/LF.
module matrix_print_streamer #(
  parameter int RD_LAT  = 2,
  parameter int MAX_DIM = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [2:0]  i_m,
  input  logic [2:0]  i_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CONV,
    S_EMIT_DIG,
    S_EMIT_SEP,
    S_EMIT_CR,
    S_EMIT_LF,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_m;
  logic [2:0]  r_n;
  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [7:0]  r_wait;
  logic [4:0]  r_iter;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [3:0]  r_dig_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_rd_addr;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_dims_ok;
  logic [39:0] w_bcd_adj;
  logic [39:0] w_bcd_next;
  logic [3:0]  w_lead;
  logic [3:0]  w_lead_digit;
  logic [3:0]  w_dig_idx_m1;
  logic [3:0]  w_prev_digit;
  logic        w_last_col;
  logic        w_last_row;

  function automatic logic [3:0] digit_at(input logic [39:0] v, input logic [3:0] idx);
    digit_at = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (idx == 4'(i)) digit_at = v[4*i +: 4];
    end
  endfunction

  assign w_dims_ok = (i_m != 3'd0) && (i_n != 3'd0) &&
                     (int'(i_m) <= MAX_DIM) && (int'(i_n) <= MAX_DIM);

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_bcd_adj[38:0], r_bin[31]};
  end

  // Most significant non-zero digit; index 0 when the value is zero so a single "0" is sent.
  always_comb begin
    w_lead = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_bcd_next[4*i +: 4] != 4'd0) w_lead = 4'(i);
    end
  end

  assign w_lead_digit = digit_at(w_bcd_next, w_lead);
  assign w_dig_idx_m1 = r_dig_idx - 4'd1;
  assign w_prev_digit = digit_at(r_bcd, w_dig_idx_m1);
  assign w_last_col   = (r_col == r_n - 3'd1);
  assign w_last_row   = (r_row + 3'd1 == r_m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_m        <= 3'd0;
      r_n        <= 3'd0;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_wait     <= 8'd0;
      r_iter     <= 5'd0;
      r_bin      <= 32'd0;
      r_bcd      <= 40'd0;
      r_dig_idx  <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_addr  <= 8'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_dims_ok) begin
              r_m       <= i_m;
              r_n       <= i_n;
              r_row     <= 3'd0;
              r_col     <= 3'd0;
              r_rd_addr <= i_base_addr;
              r_busy    <= 1'b1;
              r_state   <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        // The address was registered on entry so the storage sees it during this cycle.
        S_READ: begin
          r_wait  <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == 8'(RD_LAT - 1)) begin
            r_bin   <= i_rd_data;
            r_bcd   <= 40'd0;
            r_iter  <= 5'd0;
            r_state <= S_CONV;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[30:0], 1'b0};
          if (r_iter == 5'd31) begin
            r_dig_idx  <= w_lead;
            r_tx_data  <= {4'h3, w_lead_digit};
            r_tx_valid <= 1'b1;
            r_state    <= S_EMIT_DIG;
          end else begin
            r_iter <= r_iter + 5'd1;
          end
        end
        S_EMIT_DIG: begin
          if (i_tx_ready) begin
            if (r_dig_idx != 4'd0) begin
              r_dig_idx <= w_dig_idx_m1;
              r_tx_data <= {4'h3, w_prev_digit};
            end else if (!w_last_col) begin
              r_tx_data <= 8'h20;
              r_state   <= S_EMIT_SEP;
            end else begin
              r_tx_data <= 8'h0D;
              r_state   <= S_EMIT_CR;
            end
          end
        end
        // Elements are row-major and contiguous, so base + row*n + col is the previous address + 1.
        S_EMIT_SEP: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_col      <= r_col + 3'd1;
            r_rd_addr  <= r_rd_addr + 8'd1;
            r_state    <= S_READ;
          end
        end
        S_EMIT_CR: begin
          if (i_tx_ready) begin
            r_tx_data <= 8'h0A;
            r_state   <= S_EMIT_LF;
          end
        end
        S_EMIT_LF: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_col      <= 3'd0;
            r_row      <= r_row + 3'd1;
            if (w_last_row) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rd_addr <= r_rd_addr + 8'd1;
              r_state   <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rd_addr  = r_rd_addr;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_matrix_print_streamer.sv
// tb/tb_matrix_print_streamer.sv - scoreboard bench for matrix_print_streamer.
// Stimulus pushes expected bytes; a negedge monitor pops and compares each transfer.
module tb_matrix_print_streamer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_base_addr;
  logic [2:0]  i_m;
  logic [2:0]  i_n;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  always #5 clk = ~clk;

  matrix_print_streamer #(.RD_LAT(2), .MAX_DIM(5)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_m(i_m), .i_n(i_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
  );

  // Storage model: address seen in cycle t returns data in cycle t+2.
  logic [31:0] mem [0:255];
  logic [7:0]  r_a;
  always @(posedge clk) begin
    r_a       <= o_rd_addr;
    i_rd_data <= mem[r_a];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] addr_log[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int byte_cnt = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] last_addr = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (o_tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_hold) begin
        chk("hold_valid", {63'd0, o_tx_valid}, 64'd1);
        chk("hold_data", {56'd0, o_tx_data}, {56'd0, prev_data});
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", o_tx_data);
        end else begin
          chk("tx_byte", {56'd0, o_tx_data}, {56'd0, exp_q.pop_front()});
        end
        byte_cnt++;
      end
      prev_hold = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      if (o_busy && o_rd_addr != last_addr) addr_log.push_back(o_rd_addr);
      last_addr = o_rd_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic start_run(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n);
    @(negedge clk);
    #1;
    i_base_addr = base;
    i_m = m;
    i_n = n;
    i_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    first_valid_cyc = -1;
    #1;
    i_start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: low for 10 cycles then toggling.
  task automatic run(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n,
                     input int mode, input bit dup);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    i_tx_ready = (mode == 0);
    start_run(base, m, n);
    for (int k = 0; k < 3000; k++) begin
      if (mode == 1) i_tx_ready = (k < 10) ? 1'b0 : ~i_tx_ready;
      if (dup && k == 5) begin
        i_base_addr = 8'h00;
        i_m = 3'd2;
        i_n = 3'd2;
        i_start = 1'b1;
      end
      if (dup && k == 6) i_start = 1'b0;
      @(posedge clk);
      #1;
      if (done_cnt != d0) break;
    end
    i_tx_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("err_pulses", 64'(err_cnt - e0), 64'd0);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
    chk({tag, "_err"}, {63'd0, o_err}, 64'd0);
    chk({tag, "_rd_addr"}, {56'd0, o_rd_addr}, 64'd0);
    chk({tag, "_tx_data"}, {56'd0, o_tx_data}, 64'd0);
    chk({tag, "_tx_valid"}, {63'd0, o_tx_valid}, 64'd0);
  endtask

  task automatic load_s1();
    mem[8'h10] = 32'd1;
    mem[8'h11] = 32'd20;
    mem[8'h12] = 32'd300;
    mem[8'h13] = 32'd0;
    mem[8'h14] = 32'd4095;
    mem[8'h15] = 32'd7;
  endtask

  logic [7:0] addr_before;
  logic       valid_seen;
  logic [2:0] bad_m [0:2];
  logic [2:0] bad_n [0:2];
  int d0;
  int b0;

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_base_addr = 8'd0;
    i_m = 3'd0;
    i_n = 3'd0;
    i_tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: 2x3 at 0x10.
    load_s1();
    push_str("1 20 300\015\0120 4095 7\015\012");
    addr_log.delete();
    run(8'h10, 3'd2, 3'd3, 0, 1'b0);
    chk("s1_first_valid_cycle", 64'(first_valid_cyc), 64'd36);
    chk("s1_addr_count", 64'(addr_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk("s1_addr", {56'd0, addr_log[i]}, 64'(8'h10 + i));

    // 1x1 max value, with a second start mid-run that must be ignored.
    mem[8'h40] = 32'hFFFF_FFFF;
    push_str("4294967295\015\012");
    run(8'h40, 3'd1, 3'd1, 0, 1'b1);

    mem[8'h41] = 32'd0;
    push_str("0\015\012");
    run(8'h41, 3'd1, 3'd1, 0, 1'b0);

    // Backpressure: 2x2 of 9.
    for (int i = 0; i < 4; i++) mem[8'h80 + i] = 32'd9;
    push_str("9 9\015\0129 9\015\012");
    run(8'h80, 3'd2, 3'd2, 1, 1'b0);

    // Illegal dimensions.
    bad_m[0] = 3'd0; bad_n[0] = 3'd3;
    bad_m[1] = 3'd3; bad_n[1] = 3'd6;
    bad_m[2] = 3'd7; bad_n[2] = 3'd3;
    i_tx_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      addr_before = o_rd_addr;
      d0 = done_cnt;
      start_run(8'h55, bad_m[t], bad_n[t]);
      @(negedge clk);
      #1;
      chk("illegal_done", {63'd0, o_done}, 64'd1);
      chk("illegal_err", {63'd0, o_err}, 64'd1);
      chk("illegal_busy", {63'd0, o_busy}, 64'd0);
      valid_seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (o_tx_valid || o_busy) valid_seen = 1'b1;
      end
      chk("illegal_no_tx", {63'd0, valid_seen}, 64'd0);
      chk("illegal_addr_kept", {56'd0, o_rd_addr}, {56'd0, addr_before});
      chk("illegal_done_count", 64'(done_cnt - d0), 64'd1);
    end

    // Address wrap-around.
    mem[8'hFE] = 32'd5;
    mem[8'hFF] = 32'd6;
    mem[8'h00] = 32'd7;
    push_str("5 6 7\015\012");
    addr_log.delete();
    run(8'hFE, 3'd1, 3'd3, 0, 1'b0);
    chk("wrap_addr_count", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() == 3) begin
      chk("wrap_addr0", {56'd0, addr_log[0]}, 64'hFE);
      chk("wrap_addr1", {56'd0, addr_log[1]}, 64'hFF);
      chk("wrap_addr2", {56'd0, addr_log[2]}, 64'h00);
    end

    // Reset while the third byte of scenario 1 is on the interface.
    push_str("1 20 300\015\0120 4095 7\015\012");
    b0 = byte_cnt;
    i_tx_ready = 1'b1;
    start_run(8'h10, 3'd2, 3'd3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (byte_cnt == b0 + 3) break;
    end
    chk("mid_reset_reached", 64'(byte_cnt - b0), 64'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle_busy", {63'd0, o_busy}, 64'd0);
    chk("post_reset_no_valid", {63'd0, o_tx_valid}, 64'd0);
    push_str("1 20 300\015\0120 4095 7\015\012");
    run(8'h10, 3'd2, 3'd3, 0, 1'b0);
    chk("rerun_first_valid_cycle", 64'(first_valid_cyc), 64'd36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
